// File: rtl/mc_pkg.sv
// Shared types for the mc_accum_core multi-cycle accumulator CPU: opcodes,
// CTYPE function codes, controller states and the immediate sign-extender.
package mc_pkg;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'd0,
        OP_STORE = 4'd1,
        OP_JUMP  = 4'd2,
        OP_BZ    = 4'd4,
        OP_CTYPE = 4'd8,
        OP_ADDI  = 4'd12,
        OP_SUBI  = 4'd13,
        OP_ANDI  = 4'd14,
        OP_ORI   = 4'd15
    } opcode_e;

    typedef enum logic [3:0] {
        F_MOVETO   = 4'd0,
        F_MOVEFROM = 4'd1,
        F_ADD      = 4'd2,
        F_SUB      = 4'd3,
        F_AND      = 4'd4,
        F_OR       = 4'd5,
        F_NOT      = 4'd6,
        F_NOP      = 4'd7
    } func_e;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    // Sign-extend the low w bits of v to 64 bits; callers truncate to DATA_W.
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = $signed(v << (64 - w));
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// NREG x DATA_W register file: one combinational read port, an R0 tap for
// the accumulator, one synchronous write port, async clear.
module mc_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    localparam int RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] r0
);

    logic [NREG-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];
    assign r0    = regs[0];

endmodule

// File: rtl/mc_accum_core.sv
// Multi-cycle accumulator CPU with a req/ack memory port. Define
// ILLEGAL_TRAP_EN to trap illegal opcodes into HALT and expose the halted port.
module mc_accum_core
    import mc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NREG     = 8,
    parameter int RESET_PC = 0,
    localparam int ADDR_W  = DATA_W - 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              retire,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [DATA_W-1:0] acc_dbg,
    output logic              zero_flag
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic              halted
`endif
);

    localparam int RW = $clog2(NREG);

    state_e            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx, addr;
    logic [DATA_W-1:0] ir, a_reg, alu_out, alu_res, mdr, acc, rdata, wdata, imm;
    logic [RW-1:0]     ridx, waddr;
    opcode_e           op;
    func_e             func;
    logic              we, req, req_we, retire_c;

    assign op   = opcode_e'(ir[DATA_W-1 -: 4]);
    assign func = func_e'(ir[3:0]);
    assign addr = ir[ADDR_W-1:0];
    assign ridx = ir[ADDR_W-1 -: RW];
    assign imm  = DATA_W'(sext(64'(addr), ADDR_W));

    mc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (ridx),
        .rdata (rdata),
        .r0    (acc)
    );

    always_comb begin
        alu_res = acc;
        case (op)
            OP_CTYPE: begin
                case (func)
                    F_MOVEFROM: alu_res = a_reg;
                    F_ADD:      alu_res = acc + a_reg;
                    F_SUB:      alu_res = acc - a_reg;
                    F_AND:      alu_res = acc & a_reg;
                    F_OR:       alu_res = acc | a_reg;
                    F_NOT:      alu_res = ~a_reg;
                    default:    alu_res = acc;
                endcase
            end
            OP_ADDI: alu_res = acc + imm;
            OP_SUBI: alu_res = acc - imm;
            OP_ANDI: alu_res = acc & imm;
            OP_ORI:  alu_res = acc | imm;
            default: alu_res = acc;
        endcase
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        req      = 1'b0;
        req_we   = 1'b0;
        retire_c = 1'b0;
        we       = 1'b0;
        waddr    = '0;
        wdata    = alu_out;
        case (state)
            FETCH: begin
                req = 1'b1;
                if (mem_ack) state_nx = DECODE;
            end
            DECODE: begin
                pc_nx = pc + ADDR_W'(1);
                case (op)
                    OP_JUMP: begin
                        pc_nx    = addr;
                        retire_c = 1'b1;
                        state_nx = FETCH;
                    end
                    OP_BZ: begin
                        if (acc == '0) pc_nx = addr;
                        retire_c = 1'b1;
                        state_nx = FETCH;
                    end
                    OP_LOAD, OP_STORE: state_nx = MEM;
                    OP_CTYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_nx = EXEC;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_nx = HALT;
`else
                        retire_c = 1'b1;
                        state_nx = FETCH;
`endif
                    end
                endcase
            end
            EXEC: state_nx = WB;
            MEM: begin
                req    = 1'b1;
                req_we = (op == OP_STORE);
                if (mem_ack) begin
                    if (op == OP_STORE) begin
                        retire_c = 1'b1;
                        state_nx = FETCH;
                    end else begin
                        state_nx = WB;
                    end
                end
            end
            WB: begin
                // EXEC leaves R0 in alu_out for non-writing CTYPE funcs, so always write.
                we       = 1'b1;
                retire_c = 1'b1;
                state_nx = FETCH;
                if (op == OP_LOAD) wdata = mdr;
                if (op == OP_CTYPE && func == F_MOVETO) waddr = ridx;
            end
            HALT: state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= ADDR_W'(RESET_PC);
            ir      <= '0;
            a_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == FETCH && mem_ack) ir <= mem_rdata;
            if (state == DECODE) a_reg <= rdata;
            if (state == EXEC) alu_out <= alu_res;
            if (state == MEM && mem_ack && op == OP_LOAD) mdr <= mem_rdata;
        end
    end

    // Reset must drop the request in the same instant, not at the next edge.
    assign mem_req   = req & ~rst;
    assign mem_we    = req_we & ~rst;
    assign mem_addr  = (state == MEM) ? addr : pc;
    assign mem_wdata = acc;
    assign retire    = retire_c & ~rst;
    assign pc_dbg    = pc;
    assign acc_dbg   = acc;
    assign zero_flag = (acc == '0);
`ifdef ILLEGAL_TRAP_EN
    assign halted    = (state == HALT);
`endif

endmodule

// File: tb/tb_mc_accum_core.sv
// Bench for mc_accum_core: ISA-level reference model plus a wait-state memory,
// directed programs with literal expectations and a randomized run.
`timescale 1ns/1ps
module tb_mc_accum_core;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req, mem_we, mem_ack, retire, zero_flag;
    logic [AW-1:0] mem_addr, pc_dbg;
    logic [DW-1:0] mem_wdata, mem_rdata, acc_dbg;
`ifdef ILLEGAL_TRAP_EN
    logic          halted;
`endif

    always #5 clk = ~clk;

    mc_accum_core #(.DATA_W(DW), .NREG(NR), .RESET_PC(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .retire    (retire),
        .pc_dbg    (pc_dbg),
        .acc_dbg   (acc_dbg),
        .zero_flag (zero_flag)
`ifdef ILLEGAL_TRAP_EN
        ,
        .halted    (halted)
`endif
    );

    logic [DW-1:0] mem [0:4095];
    int checks = 0, failures = 0, cyc = 0, n_ret = 0;
    int wmode = 0;
    bit hold_data = 0;

    // architectural model
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_r [NR];
    int ph = 0;  // 0 expect fetch, 1 fetching, 2 executing, 3 data access, 4 halted
    bit p_mem, p_we, p_done, p_halt, chk_next;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    int p_lat, icnt, waits, hcnt, wcnt;
    bit req_seen, prev_req, prev_we;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    int fetch_log[$], retire_cyc[$];
    logic [DW-1:0] acc_log[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic issue(input logic [DW-1:0] iw);
        logic [3:0] op, f;
        logic [AW-1:0] a;
        logic [2:0] r;
        logic [DW-1:0] imm, acc, x;
        op = iw[15:12]; a = iw[11:0]; r = iw[11:9]; f = iw[3:0];
        imm = {{4{a[11]}}, a};
        acc = m_r[0]; x = m_r[r];
        p_mem = 0; p_we = 0; p_addr = a; p_wdata = acc; p_done = 0; p_halt = 0; p_lat = 4;
        m_pc = m_pc + 12'd1;
        case (op)
            4'd0: begin p_mem = 1; m_r[0] = mem[a]; end
            4'd1: begin p_mem = 1; p_we = 1; p_lat = 3; end
            4'd2: begin m_pc = a; p_lat = 2; end
            4'd4: begin if (acc == 0) m_pc = a; p_lat = 2; end
            4'd8: begin
                case (f)
                    4'd0: m_r[r] = acc;
                    4'd1: m_r[0] = x;
                    4'd2: m_r[0] = acc + x;
                    4'd3: m_r[0] = acc - x;
                    4'd4: m_r[0] = acc & x;
                    4'd5: m_r[0] = acc | x;
                    4'd6: m_r[0] = ~x;
                    default: ;
                endcase
            end
            4'd12: m_r[0] = acc + imm;
            4'd13: m_r[0] = acc - imm;
            4'd14: m_r[0] = acc & imm;
            4'd15: m_r[0] = acc | imm;
            default: begin
                p_lat = 2;
`ifdef ILLEGAL_TRAP_EN
                p_halt = 1;
`endif
            end
        endcase
    endtask

    task automatic observe();
        if (chk_next) begin
            chk("pc_after_retire", 32'(pc_dbg), 32'(m_pc));
            chk("acc_after_retire", 32'(acc_dbg), 32'(m_r[0]));
            chk("zero_flag", 32'(zero_flag), 32'(m_r[0] == 0));
            acc_log.push_back(acc_dbg);
            chk_next = 0;
        end
        if (ph != 0 && ph != 4) icnt++;
        if (ph == 4) begin
            hcnt++;
            chk("halt_no_req", 32'(mem_req), 32'd0);
            chk("halt_no_retire", 32'(retire), 32'd0);
            if (hcnt >= 2) begin
`ifdef ILLEGAL_TRAP_EN
                chk("halted", 32'(halted), 32'd1);
`endif
                chk("halt_pc", 32'(pc_dbg), 32'(m_pc));
            end
        end
        if (mem_req && ph != 4) begin
            if (prev_req) begin
                chk("stable_addr", 32'(mem_addr), 32'(prev_addr));
                chk("stable_we", 32'(mem_we), 32'(prev_we));
                chk("stable_wdata", 32'(mem_wdata), 32'(prev_wdata));
            end
            if (ph == 0) begin
                chk("fetch_addr", 32'(mem_addr), 32'(m_pc));
                chk("fetch_we", 32'(mem_we), 32'd0);
                fetch_log.push_back(int'(mem_addr));
                ph = 1; icnt = 1; waits = 0;
            end else if (ph == 2) begin
                if (!p_mem || p_done) begin
                    chk("unexpected_req", 32'(mem_req), 32'd0);
                end else begin
                    chk("data_addr", 32'(mem_addr), 32'(p_addr));
                    chk("data_we", 32'(mem_we), 32'(p_we));
                    if (p_we) chk("store_data", 32'(mem_wdata), 32'(p_wdata));
                    ph = 3;
                end
            end
            if (!mem_ack) waits++;
            else if (ph == 1) begin
                issue(mem[m_pc]);
                ph = p_halt ? 4 : 2;
                hcnt = 0;
            end else if (ph == 3) begin
                p_done = 1;
                ph = 2;
            end
        end
        prev_req = mem_req && !mem_ack;
        prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
        if (retire) begin
            if (ph != 2 || (p_mem && !p_done)) begin
                chk("unexpected_retire", 32'(retire), 32'd0);
            end else begin
                chk("latency", 32'(icnt), 32'(p_lat + waits));
                retire_cyc.push_back(cyc);
                n_ret++;
                ph = 0;
                chk_next = 1;
            end
        end
    endtask

    // memory responder and per-cycle compare
    initial begin
        mem_ack = 0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack = 0; req_seen = 0; ph = 0; m_pc = '0; chk_next = 0;
                prev_req = 0; cyc = 0;
                for (int i = 0; i < NR; i++) m_r[i] = '0;
                #1;
                chk("rst_req", 32'(mem_req), 32'd0);
                chk("rst_retire", 32'(retire), 32'd0);
                chk("rst_acc", 32'(acc_dbg), 32'd0);
            end else begin
                cyc++;
                if (mem_req) begin
                    if (!req_seen) begin
                        req_seen = 1;
                        if (ph == 0 || ph == 1)
                            wcnt = (wmode == 2) ? int'($urandom_range(0, 3)) : 0;
                        else if (hold_data)
                            wcnt = 1000000;
                        else
                            wcnt = (wmode == 1) ? 3 : (wmode == 2) ? int'($urandom_range(0, 3)) : 0;
                    end
                    if (wcnt == 0) begin
                        mem_ack = 1;
                        mem_rdata = mem[mem_addr];
                        if (mem_we) mem[mem_addr] = mem_wdata;
                        req_seen = 0;
                    end else begin
                        mem_ack = 0;
                        mem_rdata = 16'($urandom);
                        wcnt--;
                    end
                end else begin
                    mem_ack = 0;
                    mem_rdata = 16'($urandom);
                end
                #1;
                observe();
            end
        end
    end

    task automatic begin_test();
        rst = 1;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h8007;
    endtask

    task automatic release_rst();
        @(negedge clk);
        #3;
        fetch_log.delete(); retire_cyc.delete(); acc_log.delete();
        rst = 0;
    endtask

    task automatic wait_acc(input int n, input int budget);
        for (int k = 0; k < budget && acc_log.size() < n; k++) @(negedge clk);
        #3;
        chk("acc_log_count", 32'(acc_log.size() >= n), 32'd1);
    endtask

    initial begin
        int ret0;
        logic [3:0] ops[9];
        ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15};

        // reset + immediate ops
        begin_test();
        mem[0] = 16'hC005; mem[1] = 16'hD007; wmode = 0;
        release_rst();
        @(negedge clk); #2;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'd0);
        @(negedge clk); @(negedge clk); #2;
        chk("pc_after_decode", 32'(pc_dbg), 32'd1);
        wait_acc(2, 60);
        chk("addi_retire_cyc", 32'(retire_cyc[0]), 32'd4);
        chk("subi_retire_cyc", 32'(retire_cyc[1]), 32'd8);
        chk("addi_acc", 32'(acc_log[0]), 32'h0005);
        chk("subi_acc", 32'(acc_log[1]), 32'hFFFE);

        // load/store with 3 data wait states
        begin_test();
        mem[0] = 16'h00A0; mem[1] = 16'h10B0; mem[12'h0A0] = 16'h1234; mem[12'h0B0] = 16'h0;
        wmode = 1;
        release_rst();
        wait_acc(2, 80);
        chk("load_retire_cyc", 32'(retire_cyc[0]), 32'd7);
        chk("store_retire_cyc", 32'(retire_cyc[1]), 32'd13);
        chk("load_acc", 32'(acc_log[0]), 32'h1234);
        chk("store_mem", 32'(mem[12'h0B0]), 32'h1234);

        // branches and PC wrap
        begin_test();
        mem[0] = 16'h4010; mem[12'h010] = 16'hC001; mem[12'h011] = 16'h4020;
        mem[12'h012] = 16'h2FFF; mem[12'hFFF] = 16'hC001;
        wmode = 0;
        release_rst();
        for (int k = 0; k < 200 && fetch_log.size() < 6; k++) @(negedge clk);
        #3;
        chk("fetch_count", 32'(fetch_log.size() >= 6), 32'd1);
        chk("bz_taken", 32'(fetch_log[1]), 32'h010);
        chk("bz_not_taken", 32'(fetch_log[3]), 32'h012);
        chk("jump_target", 32'(fetch_log[4]), 32'hFFF);
        chk("pc_wrap", 32'(fetch_log[5]), 32'h000);

        // register ops
        begin_test();
        mem[0] = 16'hC003; mem[1] = 16'h8A00; mem[2] = 16'hC001; mem[3] = 16'h8A02; mem[4] = 16'h8A06;
        release_rst();
        wait_acc(5, 100);
        chk("add_r5", 32'(acc_log[3]), 32'h0007);
        chk("not_r5", 32'(acc_log[4]), 32'hFFFC);

        // reset while a store waits for ack
        begin_test();
        mem[0] = 16'hC009; mem[1] = 16'h1050; mem[12'h050] = 16'hAAAA;
        hold_data = 1;
        release_rst();
        for (int k = 0; k < 50 && !(mem_req && mem_we); k++) begin
            @(negedge clk); #2;
        end
        chk("store_req_seen", 32'(mem_req && mem_we), 32'd1);
        repeat (3) @(negedge clk);
        #3 rst = 1;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_retire", 32'(retire), 32'd0);
        chk("mid_rst_acc", 32'(acc_dbg), 32'd0);
        @(negedge clk); @(negedge clk); #2;
        chk("no_store_write", 32'(mem[12'h050]), 32'hAAAA);
        hold_data = 0;

        // illegal opcode
        begin_test();
        mem[0] = 16'hC001; mem[1] = 16'h3000; mem[2] = 16'hC002;
        wmode = 0;
        release_rst();
        repeat (40) @(negedge clk);
        #3;
`ifdef ILLEGAL_TRAP_EN
        chk("trap_halted", 32'(halted), 32'd1);
        chk("trap_pc", 32'(pc_dbg), 32'd2);
        chk("trap_fetches", 32'(fetch_log.size()), 32'd2);
        chk("trap_acc", 32'(acc_dbg), 32'd1);
`else
        chk("illegal_retire_cyc", 32'(retire_cyc[1]), 32'd6);
        chk("illegal_next_fetch", 32'(fetch_log[2]), 32'd2);
        chk("illegal_then_addi", 32'(acc_log[2]), 32'd3);
`endif

        // randomized programs with random wait states and a mid-run reset
        for (int round = 0; round < 2; round++) begin
            begin_test();
            for (int i = 0; i < 4096; i++) begin
                logic [3:0] op;
                op = ops[$urandom_range(0, 8)];
`ifndef ILLEGAL_TRAP_EN
                if ($urandom_range(0, 31) == 0) op = 4'd3;
`endif
                mem[i] = {op, 12'($urandom)};
            end
            wmode = 2;
            release_rst();
            ret0 = n_ret;
            repeat (1500) @(negedge clk);
            #3 rst = 1;
            @(negedge clk);
            #3 rst = 0;
            repeat (1500) @(negedge clk);
            #3;
            chk("random_progress", 32'(n_ret - ret0 > 100), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
